// File: rtl/exe_mul_sequencer.sv
// Iterative MUL/MLA unit beside the EXE ALU: shift-add over WIDTH/BITS_PER_CYCLE cycles, optional accumulate, one-cycle done.
// Latency ITERS+1 (MUL) / ITERS+2 (MLA); freezes upstream pipeline while computing, flush cancels without side effects.
module exe_mul_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] op_m,
    input  logic [WIDTH-1:0] op_s,
    input  logic [WIDTH-1:0] op_n,
    input  logic [3:0]       status_reg_in,
    input  logic             flush,
    output logic             freeze,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status_reg_out,
    output logic             status_wr_en
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mplier, addend, prod;
    logic [WIDTH-1:0] prod_step, prod_final;
    logic             acc_q, sbit_q;
    logic [1:0]       cv_q;
    logic             accept, calc_last, load_result;
    logic             unused_flags;

    assign unused_flags = ^status_reg_in[3:2];

    assign accept      = (state == IDLE) && start && !flush;
    assign calc_last   = (state == CALC) && (cnt == '0);
    assign load_result = !flush && ((calc_last && !acc_q) || (state == ACC));

    // Retire BITS_PER_CYCLE multiplier LSBs; mcand is pre-shifted so bit b weighs mcand<<b.
    always_comb begin
        prod_step = prod;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (mplier[b]) begin
                prod_step = prod_step + (mcand << b);
            end
        end
        prod_final = calc_last ? prod_step : (prod + addend);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = acc_q ? ACC : DONE;
            ACC:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            addend         <= '0;
            prod           <= '0;
            acc_q          <= 1'b0;
            sbit_q         <= 1'b0;
            cv_q           <= 2'b00;
            result         <= '0;
            status_reg_out <= 4'b0000;
        end else begin
            if (accept) begin
                mcand  <= op_m;
                mplier <= op_s;
                addend <= op_n;
                acc_q  <= accumulate;
                sbit_q <= s_bit;
                cv_q   <= status_reg_in[1:0];
                cnt    <= CW'(ITERS - 1);
                prod   <= '0;
            end else if ((state == CALC) && !flush) begin
                prod   <= prod_step;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
            // Result and flags are latched on entry to DONE so they hold until the next operation.
            if (load_result) begin
                result         <= prod_final;
                status_reg_out <= {prod_final[WIDTH-1], (prod_final == '0), cv_q};
            end
        end
    end

    assign busy         = (state != IDLE);
    assign freeze       = accept || (state == CALC) || (state == ACC);
    assign done         = (state == DONE) && !flush;
    assign status_wr_en = done && sbit_q;

endmodule

// File: doc/exe_mul_sequencer.md
# exe_mul_sequencer

Multi-cycle multiply sequencer that sits beside the EXE stage ALU and executes MUL/MLA instructions iteratively. It captures operands when a multiply enters EXE and freezes the upstream pipeline while it computes. It then presents a 32-bit result and the updated NZCV flags for exactly one cycle, so the EXE/MEM pipeline register captures them. A flush cancels any operation in progress without side effects.

## Interface
- WIDTH, 32: operand and result width.
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4. ITERS = WIDTH/BITS_PER_CYCLE.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  a multiply instruction is valid in EXE.
- accumulate  in  1  1 = MLA, 0 = MUL; sampled with start.
- s_bit  in  1  update flags; sampled with start.
- op_m  in  WIDTH  multiplicand (Rm value).
- op_s  in  WIDTH  multiplier (Rs value).
- op_n  in  WIDTH  accumulator (Rn value); used only for MLA.
- status_reg_in  in  4  current flags, {N,Z,C,V}; sampled with start.
- flush  in  1  branch-taken flush; kills the current operation.
- freeze  out  1  holds IF/ID/EXE pipeline registers.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle result-valid pulse.
- result  out  WIDTH  low WIDTH bits of (op_m*op_s [+ op_n]).
- status_reg_out  out  4  updated flags {N,Z,C,V}.
- status_wr_en  out  1  high with done when s_bit was captured as 1.

## Operation
- The FSM has four states:
  - IDLE: waits for an operation.
  - CALC: runs ITERS cycles of shift-add, retiring BITS_PER_CYCLE multiplier LSBs per cycle into the partial product.
  - ACC: one cycle, MLA only; adds the captured op_n.
  - DONE: one cycle; presents the result.
- Transitions:
  - IDLE -> CALC when start=1 and flush=0. op_m, op_s, op_n, accumulate, s_bit and status_reg_in are registered; the iteration counter loads ITERS-1; the partial product clears to 0.
  - CALC -> ACC when the counter reaches 0 and accumulate=1. CALC -> DONE when the counter reaches 0 and accumulate=0.
  - ACC -> DONE unconditionally.
  - DONE -> IDLE unconditionally. start seen in DONE is the same instruction and is ignored.
  - Any state -> IDLE on flush=1 (checked after reset). No done and no status_wr_en are produced for the killed operation.
- Arithmetic is modulo 2^WIDTH; all carries out of bit WIDTH-1 are discarded. Operands are unsigned; the low WIDTH bits are identical for signed operands.
- Flags are computed in DONE:
  - N = result[WIDTH-1]
  - Z = (result == 0)
  - C and V are passed through unchanged from the captured status_reg_in.
- Operands are captured only at start. Input changes during CALC or ACC have no effect.
- Outputs:
  - freeze = (start & ~flush & state==IDLE) | state==CALC | state==ACC. freeze is low in DONE, so the pipeline advances on the edge that ends DONE.
  - result and status_reg_out are held between operations. They are meaningful only while done=1.
- Reset (rst=0 at a rising edge) forces IDLE from any state.
  - Reset values: freeze=0 (with start=0), busy=0, done=0, status_wr_en=0, result=0, status_reg_out=0, counter=0.
  - Reset takes priority over flush and start.

## Timing
- Start is presented in cycle 0, with freeze high combinationally in that same cycle.
- done=1 in cycle ITERS+1 for MUL and ITERS+2 for MLA. With the defaults, MUL completes in cycle 33 and MLA in cycle 34.
- BITS_PER_CYCLE=4 gives ITERS=8: MUL done in cycle 9.
- Back-to-back: a new start may be accepted in the cycle immediately after DONE.
- flush in cycle k (k ≥ 1, operation active): state is IDLE in cycle k+1. busy=0 and freeze=0 in cycle k+1 unless a new start is present.
- A flush coincident with start in IDLE: the operation is not accepted and freeze stays low.

## Test plan
- MUL 7×6, s_bit=0, defaults → done in cycle 33; result=0x0000002A; status_wr_en=0; freeze high in cycles 0–32.
- MLA 0xFFFFFFFF×2 + 5, s_bit=1, status_reg_in=4'b0011 → done in cycle 34; result=0x00000003; status_reg_out=4'b0011.
- MUL 0x00010000×0x00010000, s_bit=1, status_reg_in=4'b1010 → result=0x00000000; status_reg_out=4'b0110; status_wr_en=1 for exactly one cycle.
- Start MUL, change op_m/op_s in cycle 5, flush in cycle 10 → busy=0 in cycle 11; done never asserted. A following MUL 3×3 returns 0x00000009.
- rst=0 in cycle 15 of an MLA, then release → all outputs at reset values. A new MUL 0x80000000×1 with s_bit=1 yields N=1.
- BITS_PER_CYCLE=4, back-to-back MUL 0x12345678×0x10 then 0xFFFF×0xFFFF → results 0x23456780 and 0xFFFE0001 with done in cycles 9 and 19.
